// File: rtl/line_mem_responder.sv
// Line-wide memory responder: small reset-cleared line store answering each
// cache line request after a fixed latency with a one-cycle mem_ready pulse.
// Also flags initiator protocol violations and counts completed transactions.
module line_mem_responder #(
   parameter int unsigned ADDR_W     = 28,
   parameter int unsigned DATA_W     = 128,
   parameter int unsigned DEPTH_LOG2 = 6,
   parameter int unsigned LATENCY    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              protocol_err,
   output logic [15:0]       rd_cnt,
   output logic [15:0]       wr_cnt
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic                op_wr;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [DATA_W-1:0]   store [DEPTH];

   logic [DEPTH_LOG2-1:0] lat_idx;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic                  req;

   assign lat_idx = lat_addr[DEPTH_LOG2-1:0];
   assign req_idx = mem_addr[DEPTH_LOG2-1:0];
   assign req     = mem_read | mem_write;

   // Transaction FSM with latency counter, registered outputs and statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         op_wr        <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         mem_ready    <= 1'b0;
         mem_rdata    <= '0;
         protocol_err <= 1'b0;
         rd_cnt       <= '0;
         wr_cnt       <= '0;
      end else begin
         mem_ready <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req) begin
                  op_wr     <= mem_write;
                  lat_addr  <= mem_addr;
                  lat_wdata <= mem_wdata;
                  cnt       <= CNT_LOAD;
                  if (mem_read && mem_write) protocol_err <= 1'b1;
                  if (LATENCY == 1) begin
                     // No wait phase: respond on the very next cycle.
                     state     <= RESP;
                     mem_ready <= 1'b1;
                     if (!mem_write) mem_rdata <= store[req_idx];
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if ((mem_addr != lat_addr) || !req) protocol_err <= 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state     <= RESP;
                  mem_ready <= 1'b1;
                  if (!op_wr) mem_rdata <= store[lat_idx];
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               state <= IDLE;
               if (op_wr) begin
                  if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
               end else begin
                  if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Line store; a write lands on the edge leaving RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store <= '{default: '0};
      end else if (state == RESP && op_wr) begin
         store[lat_idx] <= lat_wdata;
      end
   end

endmodule

// File: tb/tb_line_mem_responder.sv
// Scoreboard bench for line_mem_responder: one instance at LATENCY=4 and one
// at LATENCY=1; expected responses are queued at issue and popped on mem_ready.
module tb_line_mem_responder;

   localparam int unsigned AW = 28;
   localparam int unsigned DW = 128;

   typedef struct {
      int              cyc;
      bit              is_rd;
      logic [DW-1:0]   data;
   } exp_t;

   logic clk;
   logic rst_n;

   logic          rd4, wr4, rdy4, perr4;
   logic [AW-1:0] addr4;
   logic [DW-1:0] wdata4, rdata4;
   logic [15:0]   rdc4, wrc4;

   logic          rd1, wr1, rdy1, perr1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1, rdata1;
   logic [15:0]   rdc1, wrc1;

   int   cyc;
   int   checks;
   int   failures;
   exp_t q4[$];
   exp_t q1[$];
   int   exp_rd[2];
   int   exp_wr[2];

   line_mem_responder #(.LATENCY(4)) u4 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd4), .mem_write(wr4),
      .mem_addr(addr4), .mem_wdata(wdata4), .mem_rdata(rdata4),
      .mem_ready(rdy4), .protocol_err(perr4), .rd_cnt(rdc4), .wr_cnt(wrc4)
   );

   line_mem_responder #(.LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .mem_read(rd1), .mem_write(wr1),
      .mem_addr(addr1), .mem_wdata(wdata1), .mem_rdata(rdata1),
      .mem_ready(rdy1), .protocol_err(perr1), .rd_cnt(rdc1), .wr_cnt(wrc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Monitor for the LATENCY=4 instance.
   always @(negedge clk) begin
      if (rst_n && rdy4) begin
         if (q4.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready4 actual=1 expected=0 cyc=%0d", cyc);
         end else begin
            exp_t e;
            e = q4.pop_front();
            chk("ready_cycle4", DW'(cyc), DW'(e.cyc));
            if (e.is_rd) chk("rdata4", rdata4, e.data);
         end
      end
   end

   // Monitor for the LATENCY=1 instance.
   always @(negedge clk) begin
      if (rst_n && rdy1) begin
         if (q1.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready1 actual=1 expected=0 cyc=%0d", cyc);
         end else begin
            exp_t e;
            e = q1.pop_front();
            chk("ready_cycle1", DW'(cyc), DW'(e.cyc));
            if (e.is_rd) chk("rdata1", rdata1, e.data);
         end
      end
   end

   // Issue one transaction in the current cycle, hold until mem_ready, then drop.
   task automatic xact(input bit sel1, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp_data);
      exp_t e;
      bit   seen;
      e.cyc   = cyc + (sel1 ? 1 : 4);
      e.is_rd = rd && !wr;
      e.data  = exp_data;
      if (sel1) begin
         rd1 = rd; wr1 = wr; addr1 = a; wdata1 = wd;
         q1.push_back(e);
      end else begin
         rd4 = rd; wr4 = wr; addr4 = a; wdata4 = wd;
         q4.push_back(e);
      end
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (sel1 ? rdy1 : rdy4) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL ready_timeout actual=0 expected=1 addr=%h", a);
      end
      @(posedge clk);
      #1;
      if (sel1) begin
         rd1 = 1'b0; wr1 = 1'b0;
      end else begin
         rd4 = 1'b0; wr4 = 1'b0;
      end
      if (wr) exp_wr[sel1 ? 1 : 0]++;
      else    exp_rd[sel1 ? 1 : 0]++;
   endtask

   task automatic chk_cnt4(input string nm);
      chk({nm, "_rd_cnt"}, DW'(rdc4), DW'(exp_rd[0]));
      chk({nm, "_wr_cnt"}, DW'(wrc4), DW'(exp_wr[0]));
   endtask

   initial begin
      cyc = 0; checks = 0; failures = 0;
      exp_rd = '{0, 0}; exp_wr = '{0, 0};
      rst_n = 1'b0;
      rd4 = 0; wr4 = 0; addr4 = '0; wdata4 = '0;
      rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready", DW'(rdy4), DW'(0));
      chk("reset_rdata", rdata4, DW'(0));
      chk("reset_perr", DW'(perr4), DW'(0));
      chk_cnt4("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic read of a cleared line: ready 4 cycles after acceptance.
      xact(0, 1, 0, 28'h5, '0, 128'h0);
      chk_cnt4("rd1");

      // Write then back-to-back read of the same line.
      xact(0, 0, 1, 28'h3, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, '0);
      chk("rdata_after_write", rdata4, 128'h0);
      xact(0, 1, 0, 28'h3, '0, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
      chk("rdata_held", rdata4, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
      chk_cnt4("wr_rd");
      chk("perr_clean", DW'(perr4), DW'(0));

      // Aliasing: upper address bits ignored.
      xact(0, 0, 1, 28'h01, 128'h1, '0);
      xact(0, 1, 0, 28'h41, '0, 128'h1);
      chk_cnt4("alias");

      // Address change during WAIT, then reset mid-WAIT.
      rd4 = 0; wr4 = 1; addr4 = 28'h3; wdata4 = 128'hFFFF;
      @(posedge clk); #1;
      addr4 = 28'h9;
      @(posedge clk); #1;
      chk("perr_addr_change", DW'(perr4), DW'(1));
      rst_n = 1'b0;
      wr4 = 0; addr4 = '0; wdata4 = '0;
      exp_rd = '{0, 0}; exp_wr = '{0, 0};
      @(posedge clk); #1;
      chk("perr_after_reset", DW'(perr4), DW'(0));
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("abandon_perr", DW'(perr4), DW'(0));
      chk("abandon_rdata", rdata4, DW'(0));
      chk_cnt4("abandon");
      xact(0, 1, 0, 28'h3, '0, 128'h0);

      // Both read and write high: serviced as a write, sticky error.
      xact(0, 1, 1, 28'h7, 128'hAA, '0);
      chk("perr_both", DW'(perr4), DW'(1));
      xact(0, 1, 0, 28'h7, '0, 128'hAA);
      chk_cnt4("both");
      chk("perr_sticky", DW'(perr4), DW'(1));

      // LATENCY=1 instance: write, then a read held one extra cycle.
      xact(1, 0, 1, 28'h0, 128'h55, '0);
      begin
         exp_t e;
         e.cyc = cyc + 1; e.is_rd = 1'b1; e.data = 128'h55;
         q1.push_back(e);
         e.cyc = cyc + 3;
         q1.push_back(e);
      end
      rd1 = 1'b1; addr1 = 28'h0;
      repeat (4) @(posedge clk);
      #1;
      rd1 = 1'b0;
      chk("lat1_rd_cnt", DW'(rdc1), DW'(2));
      chk("lat1_wr_cnt", DW'(wrc1), DW'(1));
      chk("lat1_perr", DW'(perr1), DW'(0));

      repeat (6) @(posedge clk);
      #1;
      chk("q4_drained", DW'(q4.size()), DW'(0));
      chk("q1_drained", DW'(q1.size()), DW'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/line_mem_responder.md
Name: line_mem_responder

Overview:
- Memory-side responder for the 128-bit line interface driven by the instruction and data caches (mem_read/mem_write/mem_addr/mem_wdata in, mem_rdata/mem_ready out).
- Holds a small line store and answers each request after a fixed, parameterised latency, with a one-cycle mem_ready pulse.
- Used as the slow-memory stand-in behind a cache in block benches.
- Flags initiator protocol violations and counts completed transactions.

Parameters:
ADDR_W, 28, line address width (word address minus 2 offset bits)
DATA_W, 128, line width in bits
DEPTH_LOG2, 6, log2 of lines stored; index = mem_addr[DEPTH_LOG2-1:0]
LATENCY, 4, cycles from request acceptance to the mem_ready cycle; legal range 1..255

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
mem_read  input  1  read request, level, held by initiator until mem_ready seen
mem_write  input  1  write request, level, held by initiator until mem_ready seen
mem_addr  input  ADDR_W  line address
mem_wdata  input  DATA_W  write line data
mem_rdata  output  DATA_W  read line data, registered
mem_ready  output  1  one-cycle completion pulse
protocol_err  output  1  sticky violation flag
rd_cnt  output  16  completed reads, saturating
wr_cnt  output  16  completed writes, saturating

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; mem_ready=0; mem_rdata=0; protocol_err=0; rd_cnt=wr_cnt=0.
  - All store lines = 0.
  - Reset mid-transaction abandons it: no store update, no mem_ready.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write is high at a rising edge, the request is accepted. Latched at that edge: op (write if mem_write), mem_addr, mem_wdata.
  - Down-counter is loaded with LATENCY-1. Next state is WAIT, or RESP if LATENCY=1.
  - Both mem_read and mem_write high: treated as a write; protocol_err set.
- WAIT:
  - Counter decrements each cycle; the transition to RESP occurs on the edge where the counter is 1.
  - Input changes are ignored, but protocol_err is set if mem_addr differs from the latch or the request drops. The latched transaction still completes.
- Timing:
  - Request first high in IDLE during cycle T means mem_ready=1 exactly in cycle T+LATENCY.
  - mem_ready=0 in all other cycles.
- RESP:
  - Read: mem_rdata is loaded from the store at the edge entering RESP. It is valid throughout RESP and held unchanged until the next read's RESP. Initiators may sample it the cycle after mem_ready.
  - Write: the store line is updated at the edge leaving RESP. mem_rdata is unchanged.
  - The matching counter increments at the edge leaving RESP and saturates at 16'hFFFF.
  - Next state is always IDLE.
- Back-to-back requests:
  - The cycle after RESP is IDLE. A request high then is accepted as a new transaction; initiators must drop the request the cycle after mem_ready.
  - A read accepted immediately after a write to the same line returns the new data.
- Aliasing: address bits above DEPTH_LOG2 are ignored, so lines differing only in upper bits share storage.
- protocol_err: clears only on reset.

Test Plan:
- Reset, then mem_read=1, mem_addr=28'h5 held from cycle 0 -> mem_ready high only in cycle 4; mem_rdata=0; rd_cnt=1.
- Write 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D to addr 28'h3, drop the request after ready, then read addr 28'h3 -> read ready 4 cycles after acceptance with that data; mem_rdata still held the cycle after ready; wr_cnt=1, rd_cnt=1.
- LATENCY=1, read addr 28'h0 accepted in cycle T -> mem_ready in cycle T+1. With the request held one extra cycle, a second read is accepted and rd_cnt=2.
- Read addr 28'h41 after writing 128'h1 to addr 28'h01 (DEPTH_LOG2=6) -> returns 128'h1 (alias).
- mem_read and mem_write both high, addr 28'h7, wdata 128'hAA -> serviced as a write, protocol_err=1; a later read of 28'h7 returns 128'hAA.
- Change mem_addr during WAIT, then assert rst_n low mid-WAIT -> no mem_ready, store unchanged, protocol_err=0 after reset, counters=0.
